// File: rtl/uart_rx_pkt_ctrl_pkg.sv
// Shared definitions for the UART receive packet controller.
//   - error-code constants reported on err_code
//   - FSM state encoding
//   - default start-of-frame byte
package uart_rx_pkt_ctrl_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    localparam logic [2:0] ERR_FRAMING = 3'd1;
    localparam logic [2:0] ERR_BAD_LEN = 3'd2;
    localparam logic [2:0] ERR_CSUM    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_rx_pkt_ctrl_buf.sv
// Payload buffer: DEPTH x 8 simple dual-port RAM, synchronous write,
// registered read. The read register only loads when i_rd_en is high, so
// the output holds its value while the consumer stalls.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset (read register only)
//   i_wr_en/addr/data     write port
//   i_rd_en/addr          read request, data appears on o_rd_data next cycle
//   o_rd_data             registered read data
module uart_rx_pkt_ctrl_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_data <= 8'h00;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// UART receive packet controller. Hunts the receiver byte stream for frames
// SYNC, LEN, PAYLOAD[LEN], CSUM, buffers the payload and only releases it
// downstream (valid/ready) once the checksum has passed.
// Ports:
//   x16_BAUD                     clock (16x baud), the only clock
//   reset                        synchronous, active-high
//   rx_data/rx_valid/rx_error    byte stream from the UART receiver
//   pkt_data/pkt_valid/pkt_ready/pkt_last   payload stream to the decoder
//   busy                         frame in progress or drain pending
//   err/err_code                 one-cycle error strobe, cause held until next err
//   good_cnt                     frames delivered, saturating
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | hunting for SYNC, everything else ignored
// ST_LEN     | waiting for the length byte
// ST_PAYLOAD | storing payload bytes, accumulating the sum
// ST_CSUM    | waiting for the checksum byte
// ST_DRAIN   | presenting the buffered payload, rx bytes dropped
module uart_rx_pkt_ctrl
    import uart_rx_pkt_ctrl_pkg::*;
#(
    parameter int         MAX_LEN = 16,
    parameter logic [7:0] SYNC    = SYNC_DEFAULT,
    parameter int         TIMEOUT = 4096
) (
    input  logic        x16_BAUD,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_error,
    output logic [7:0]  pkt_data,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic        pkt_last,
    output logic        busy,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [15:0] good_cnt
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [8:0]    LEN_MAX  = 9'(MAX_LEN);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_len, r_wr_ptr, r_rd_ptr;
    logic [7:0]    r_sum;
    logic [TW-1:0] r_tmr;
    logic          r_pkt_valid;
    logic          r_err;
    logic [2:0]    r_err_code;
    logic [15:0]   r_good_cnt;

    logic [PW-1:0] w_len_last, w_rd_nxt;
    logic [7:0]    w_sum_tot;
    logic          w_len_bad, w_tmo, w_hs;
    logic          w_err_det;
    logic [2:0]    w_err_code_nxt;
    logic          w_store_len, w_pay_wr, w_enter_drain;
    logic          w_rd_en, w_rd_adv, w_done;
    logic [AW-1:0] w_rd_addr;

    assign w_len_last = r_len - PTR_ONE;
    assign w_rd_nxt   = r_rd_ptr + PTR_ONE;
    assign w_sum_tot  = r_sum + rx_data;
    assign w_len_bad  = (rx_data == 8'h00) || ({1'b0, rx_data} > LEN_MAX);
    // Timer is reloaded by every received byte, so zero means TIMEOUT idle cycles.
    assign w_tmo      = (r_tmr == '0);
    assign w_hs       = r_pkt_valid & pkt_ready;

    always_ff @(posedge x16_BAUD) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_err_det      = 1'b0;
        w_err_code_nxt = ERR_FRAMING;
        w_store_len    = 1'b0;
        w_pay_wr       = 1'b0;
        w_enter_drain  = 1'b0;
        w_rd_en        = 1'b0;
        w_rd_addr      = r_rd_ptr[AW-1:0];
        w_rd_adv       = 1'b0;
        w_done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid && rx_data == SYNC) begin
                    w_state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_error) begin
                    w_err_det   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (rx_valid) begin
                    if (w_len_bad) begin
                        w_err_det      = 1'b1;
                        w_err_code_nxt = ERR_BAD_LEN;
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_store_len = 1'b1;
                        w_state_nxt = ST_PAYLOAD;
                    end
                end else if (w_tmo) begin
                    w_err_det      = 1'b1;
                    w_err_code_nxt = ERR_TIMEOUT;
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (rx_error) begin
                    w_err_det   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (rx_valid) begin
                    w_pay_wr = 1'b1;
                    if (r_wr_ptr == w_len_last) begin
                        w_state_nxt = ST_CSUM;
                    end
                end else if (w_tmo) begin
                    w_err_det      = 1'b1;
                    w_err_code_nxt = ERR_TIMEOUT;
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_CSUM: begin
                if (rx_error) begin
                    w_err_det   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (rx_valid) begin
                    if (w_sum_tot == 8'h00) begin
                        w_enter_drain = 1'b1;
                        w_state_nxt   = ST_DRAIN;
                    end else begin
                        w_err_det      = 1'b1;
                        w_err_code_nxt = ERR_CSUM;
                        w_state_nxt    = ST_IDLE;
                    end
                end else if (w_tmo) begin
                    w_err_det      = 1'b1;
                    w_err_code_nxt = ERR_TIMEOUT;
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!r_pkt_valid) begin
                    // first cycle of the drain: fetch buf[0]
                    w_rd_en = 1'b1;
                end else if (w_hs) begin
                    if (r_rd_ptr == w_len_last) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        // prefetch the next byte so a held-high ready gets one byte per cycle
                        w_rd_en   = 1'b1;
                        w_rd_addr = w_rd_nxt[AW-1:0];
                        w_rd_adv  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge x16_BAUD) begin
        if (reset) begin
            r_len       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_sum       <= 8'h00;
            r_tmr       <= TMR_LOAD;
            r_pkt_valid <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 3'd0;
            r_good_cnt  <= 16'h0000;
        end else begin
            r_err <= w_err_det;
            if (w_err_det) begin
                r_err_code <= w_err_code_nxt;
            end

            if (r_state == ST_IDLE || rx_valid) begin
                r_tmr <= TMR_LOAD;
            end else if (!w_tmo) begin
                r_tmr <= r_tmr - TW'(1);
            end

            if (w_store_len) begin
                r_len    <= PW'(rx_data);
                r_sum    <= rx_data;
                r_wr_ptr <= '0;
            end else if (w_pay_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
                r_sum    <= w_sum_tot;
            end

            if (w_enter_drain) begin
                r_rd_ptr <= '0;
            end else if (w_rd_adv) begin
                r_rd_ptr <= w_rd_nxt;
            end

            if (w_done) begin
                r_pkt_valid <= 1'b0;
            end else if (r_state == ST_DRAIN) begin
                r_pkt_valid <= 1'b1;
            end

            if (w_done && r_good_cnt != 16'hFFFF) begin
                r_good_cnt <= r_good_cnt + 16'd1;
            end
        end
    end

    uart_rx_pkt_ctrl_buf #(
        .DEPTH (MAX_LEN)
    ) u_buf (
        .i_clk     (x16_BAUD),
        .i_reset   (reset),
        .i_wr_en   (w_pay_wr),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (rx_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (pkt_data)
    );

    assign pkt_valid = r_pkt_valid;
    assign pkt_last  = r_pkt_valid && (r_rd_ptr == w_len_last);
    assign busy      = (r_state != ST_IDLE);
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign good_cnt  = r_good_cnt;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
module tb_uart_rx_pkt_ctrl;

    localparam int TIMEOUT = 4096;

    logic        x16_BAUD = 1'b0;
    logic        reset    = 1'b1;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_error = 1'b0;
    logic        pkt_ready = 1'b0;
    logic [7:0]  pkt_data;
    logic        pkt_valid, pkt_last, busy, err;
    logic [2:0]  err_code;
    logic [15:0] good_cnt;

    always #5 x16_BAUD = ~x16_BAUD;

    uart_rx_pkt_ctrl #(
        .MAX_LEN (16),
        .SYNC    (8'hA5),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .x16_BAUD  (x16_BAUD),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_error  (rx_error),
        .pkt_data  (pkt_data),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_last  (pkt_last),
        .busy      (busy),
        .err       (err),
        .err_code  (err_code),
        .good_cnt  (good_cnt)
    );

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [8:0] exp_pkt_q[$];   // {last, data}
    logic [2:0] exp_err_q[$];
    logic [7:0] pl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge x16_BAUD);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Sends SYNC, len, pl[0..len-1], checksum (+1 when bad).
    task automatic send_frame(input int len, input bit bad, input bit push);
        logic [7:0] s;
        s = 8'(len);
        send_byte(8'hA5);
        send_byte(8'(len));
        for (int i = 0; i < len; i++) begin
            send_byte(pl[i]);
            s = s + pl[i];
            if (push) exp_pkt_q.push_back({(i == len - 1), pl[i]});
        end
        if (bad) exp_err_q.push_back(3'd3);
        send_byte(8'(8'h00 - s) + (bad ? 8'h01 : 8'h00));
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200 && busy; i++) tick();
        check(name, busy, 0);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 10 && !pkt_valid; i++) tick();
        check(name, pkt_valid, 1);
    endtask

    // Monitor: scoreboard pops on handshakes and on err strobes, plus stall hold checks.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;

    always @(negedge x16_BAUD) begin
        logic [8:0] e;
        logic [2:0] c;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (err) begin
                check("err_with_valid", pkt_valid, 0);
                if (exp_err_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL err_unexpected: got code %0d expected no err", err_code);
                end else begin
                    c = exp_err_q.pop_front();
                    check("err_code_sb", err_code, c);
                end
            end
            if (prev_stall) begin
                check("stall_hold", {pkt_valid, pkt_last, pkt_data}, {1'b1, prev_last, prev_data});
            end
            if (pkt_valid && pkt_ready) begin
                if (exp_pkt_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL pkt_unexpected: got %0h expected no byte", pkt_data);
                end else begin
                    e = exp_pkt_q.pop_front();
                    check("pkt_sb", {pkt_last, pkt_data}, e);
                end
            end
            prev_stall = pkt_valid && !pkt_ready;
            prev_data  = pkt_data;
            prev_last  = pkt_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        logic pat [6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        reset = 1'b1;
        repeat (3) tick();
        check("reset_outs", {pkt_data, pkt_valid, pkt_last, busy, err, err_code}, 0);
        check("reset_good_cnt", good_cnt, 0);
        reset = 1'b0;
        tick();

        // 1: good frame A5 03 11 22 33 97, ready held high
        pkt_ready = 1'b1;
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_frame(3, 1'b0, 1'b1);
        check("t1_lat_early", pkt_valid, 0);
        tick(); check("t1_valid0", pkt_valid, 1);
        tick(); check("t1_valid1", pkt_valid, 1);
        tick(); check("t1_valid2_last", {pkt_valid, pkt_last, pkt_data}, {1'b1, 1'b1, 8'h33});
        tick(); check("t1_valid_end", pkt_valid, 0);
        wait_idle("t1_idle");
        check("t1_good_cnt", good_cnt, 1);

        // 2: same frame, checksum 98
        send_frame(3, 1'b1, 1'b0);
        check("t2_err", {err, err_code}, {1'b1, 3'd3});
        tick();
        check("t2_err_pulse", err, 0);
        check("t2_idle", {busy, pkt_valid}, 0);
        check("t2_good_cnt", good_cnt, 1);

        // 3: garbage, then bad lengths 0 and 17, then max length 16
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        tick();
        check("t3_garbage", {err, busy}, 0);
        exp_err_q.push_back(3'd2);
        send_byte(8'hA5); send_byte(8'h00);
        check("t3_len0", {err, err_code}, {1'b1, 3'd2});
        tick();
        exp_err_q.push_back(3'd2);
        send_byte(8'hA5); send_byte(8'h11);
        check("t3_len17", {err, err_code}, {1'b1, 3'd2});
        tick();
        for (int i = 0; i < 16; i++) pl[i] = 8'(i);
        send_frame(16, 1'b0, 1'b1);
        wait_idle("t3_max_idle");
        check("t3_good_cnt", good_cnt, 2);

        // 4: timeout inside payload
        exp_err_q.push_back(3'd4);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
        seen = 1'b0;
        repeat (TIMEOUT - 1) begin
            tick();
            if (err) seen = 1'b1;
        end
        check("t4_no_early_err", seen, 0);
        check("t4_still_busy", busy, 1);
        tick();
        check("t4_tmo", {err, err_code, busy}, {1'b1, 3'd4, 1'b0});
        tick();
        pl[0] = 8'h01; pl[1] = 8'h02;
        send_frame(2, 1'b0, 1'b1);
        wait_idle("t4_idle");
        check("t4_good_cnt", good_cnt, 3);

        // 5: stalled drain with rx bytes arriving meanwhile
        pkt_ready = 1'b0;
        pl[0] = 8'h5A; pl[1] = 8'hC3; pl[2] = 8'h7E;
        send_frame(3, 1'b0, 1'b1);
        wait_valid("t5_valid");
        for (int k = 0; k < 6; k++) begin
            pkt_ready = pat[k];
            rx_data   = k[0] ? 8'h01 : 8'hA5;
            rx_valid  = 1'b1;
            tick();
        end
        rx_valid  = 1'b0;
        pkt_ready = 1'b1;
        check("t5_idle", {busy, pkt_valid}, 0);
        check("t5_good_cnt", good_cnt, 4);
        repeat (4) tick();
        check("t5_no_hunt", busy, 0);

        // 6a: rx_error during payload, with rx_valid in the same cycle
        exp_err_q.push_back(3'd1);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        rx_error = 1'b1; rx_valid = 1'b1; rx_data = 8'h22;
        tick();
        rx_error = 1'b0; rx_valid = 1'b0;
        check("t6_framing", {err, err_code, busy}, {1'b1, 3'd1, 1'b0});
        tick();

        // 6b: reset in the middle of a stalled drain
        pkt_ready = 1'b0;
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_frame(3, 1'b0, 1'b0);
        wait_valid("t6_valid");
        tick();
        check("t6_stalled", {busy, pkt_valid, pkt_data}, {1'b1, 1'b1, 8'h11});
        reset = 1'b1;
        tick();
        check("t6_reset_outs", {pkt_data, pkt_valid, pkt_last, busy, err, err_code}, 0);
        check("t6_reset_good_cnt", good_cnt, 0);
        reset = 1'b0;
        pkt_ready = 1'b1;
        repeat (5) tick();
        check("t6_no_partial", {pkt_valid, busy}, 0);

        check("sb_pkt_empty", exp_pkt_q.size(), 0);
        check("sb_err_empty", exp_err_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
